// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
// Opcodes, funct codes, FSM states and datapath select values.
package mc_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_JAL   = 6'd3;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_ORI   = 6'd13;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;

    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_JAL    = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_AND = 2'd3
    } alu_op_e;

    // Instruction classes; CLS_RBAD is an R-type with an unsupported funct.
    typedef enum logic [2:0] {
        CLS_NONE, CLS_LW, CLS_SW, CLS_R, CLS_RBAD, CLS_ORI, CLS_BEQ, CLS_JAL
    } cls_e;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] DST_RD = 2'd0;
    localparam logic [1:0] DST_RT = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: OP/Funct to class, ALUOp and illegal flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output cls_e               cls,
    output alu_op_e            alu_op,
    output logic               illegal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        cls    = CLS_NONE;
        alu_op = ALU_ADD;
        case (op)
            OP_W'(OPC_LW):  cls = CLS_LW;
            OP_W'(OPC_SW):  cls = CLS_SW;
            OP_W'(OPC_JAL): cls = CLS_JAL;
            OP_W'(OPC_ORI): begin
                cls    = CLS_ORI;
                alu_op = ALU_OR;
            end
            OP_W'(OPC_BEQ): begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_W'(OPC_RTYPE): begin
                cls = CLS_R;
                case (funct)
                    FUNCT_W'(FN_ADDU): alu_op = ALU_ADD;
                    FUNCT_W'(FN_SUBU): alu_op = ALU_SUB;
                    FUNCT_W'(FN_OR):   alu_op = ALU_OR;
                    FUNCT_W'(FN_AND):  alu_op = ALU_AND;
                    default:           cls    = CLS_RBAD;
                endcase
            end
            default: cls = CLS_NONE;
        endcase
        illegal = (cls == CLS_NONE) || (cls == CLS_RBAD);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/JAL) with bounded memory wait.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions and add the illegal port.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FUNCT_W    = 6,
    parameter int ALUOP_W    = 2,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               zero,
    input  logic [OP_W-1:0]    OP,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               mem_ready,
    output logic               ALUSrc,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         NPCOp,
    output logic [1:0]         EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [2:0]         state_o,
    output logic               mem_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILL_NEXT = ST_TRAP;
`else
    localparam state_e ILL_NEXT = ST_FETCH;
`endif

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    timeout_q, timeout_d;
    cls_e                    dec_cls;
    alu_op_e                 dec_alu_op;
    logic                    dec_illegal;

    mc_ctrl_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_decode (
        .op      (OP),
        .funct   (Funct),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ALUSrc     = 1'b0;
        MemtoReg   = M2R_ALU;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        NPCOp      = NPC_PC4;
        EXTOp      = EXT_ZERO;
        ALUOp      = ALUOP_W'(ALU_ADD);
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = DST_RD;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                EXTOp = EXT_SIGN;
                case (dec_cls)
                    CLS_JAL:  state_d = ST_JAL;
                    CLS_NONE: state_d = ILL_NEXT;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    state_d = ILL_NEXT;
                end else begin
                    case (dec_cls)
                        CLS_LW, CLS_SW: begin
                            ALUSrc     = 1'b1;
                            EXTOp      = EXT_SIGN;
                            state_d    = ST_MEM;
                            wait_cnt_d = '0;
                        end
                        CLS_R: begin
                            ALUOp   = ALUOP_W'(dec_alu_op);
                            state_d = ST_WB;
                        end
                        CLS_ORI: begin
                            ALUSrc  = 1'b1;
                            ALUOp   = ALUOP_W'(dec_alu_op);
                            state_d = ST_WB;
                        end
                        CLS_BEQ: begin
                            ALUOp   = ALUOP_W'(dec_alu_op);
                            PCWrite = zero;
                            NPCOp   = zero ? NPC_BR : NPC_PC4;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
            end
            ST_MEM: begin
                MemRead  = (dec_cls == CLS_LW);
                MemWrite = (dec_cls == CLS_SW);
                // A ready on the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d    = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT - 1)) begin
                    timeout_d  = 1'b1;
                    state_d    = ST_FETCH;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                if (dec_cls == CLS_LW) begin
                    MemtoReg = M2R_MEM;
                    RegDst   = DST_RT;
                end else if (dec_cls == CLS_ORI) begin
                    RegDst   = DST_RT;
                end
                state_d = ST_FETCH;
            end
            ST_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_PC;
                RegDst   = DST_RA;
                PCWrite  = 1'b1;
                NPCOp    = NPC_JUMP;
                state_d  = ST_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: illegal = 1'b1;
`endif
            default: state_d = ST_FETCH;
        endcase

        // Reset forces every output low, not just the next state.
        if (rst) begin
            {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, NPCOp} = '0;
            {EXTOp, ALUOp, PCWrite, IRWrite, RegDst}               = '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b0;
`endif
        end
    end

    assign state_o     = rst ? 3'd0 : state_q;
    assign mem_timeout = timeout_q & ~rst;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm; expected strobes are hand-written per cycle.
// Honours MC_CTRL_ILLEGAL_TRAP_EN for the illegal-instruction cases.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       zero;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       ALUSrc, RegWrite, MemRead, MemWrite, PCWrite, IRWrite;
    logic [1:0] MemtoReg, NPCOp, EXTOp, ALUOp, RegDst;
    logic [2:0] state_o;
    logic       mem_timeout;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, J = 3'd5, T = 3'd6;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .zero        (zero),
        .OP          (OP),
        .Funct       (Funct),
        .mem_ready   (mem_ready),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .NPCOp       (NPCOp),
        .EXTOp       (EXTOp),
        .ALUOp       (ALUOp),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .state_o     (state_o),
        .mem_timeout (mem_timeout)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    wire [15:0] obs = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, NPCOp,
                       EXTOp, ALUOp, PCWrite, IRWrite, RegDst};

    // Packs one cycle's expected strobes in the same field order as obs.
    function automatic logic [15:0] s(input logic alusrc, input logic [1:0] m2r,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic [1:0] npc, input logic [1:0] ext,
                                      input logic [1:0] alu, input logic pcw,
                                      input logic irw, input logic [1:0] dst);
        return {alusrc, m2r, rw, mr, mw, npc, ext, alu, pcw, irw, dst};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already set; sample after settling, then advance one cycle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [15:0] strb,
                       input logic to);
        #1;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".strobes"}, 32'(obs), 32'(strb));
        check({tag, ".timeout"}, 32'(mem_timeout), 32'(to));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        check({tag, ".illegal"}, 32'(illegal), 32'(st == T && !rst));
`endif
        @(negedge clk);
    endtask

    logic [15:0] S_NONE, S_FETCH, S_DEC, S_LWSW_EX, S_LW_MEM, S_SW_MEM, S_LW_WB;
    logic [15:0] S_BEQ_T, S_BEQ_N, S_AND_EX, S_R_WB, S_JAL, S_ORI_EX, S_ORI_WB;

    initial begin
        S_NONE    = '0;
        S_FETCH   = s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        S_DEC     = s(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        S_LWSW_EX = s(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        S_LW_MEM  = s(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        S_SW_MEM  = s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        S_LW_WB   = s(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        S_BEQ_T   = s(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        S_BEQ_N   = s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        S_AND_EX  = s(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        S_R_WB    = s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        S_JAL     = s(0, 2, 1, 0, 0, 2, 0, 0, 1, 0, 2);
        S_ORI_EX  = s(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        S_ORI_WB  = s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1; zero = 1'b0; OP = 6'd0; Funct = 6'd0; mem_ready = 1'b0;
        @(negedge clk);
        cyc("rst0", F, S_NONE, 0);
        cyc("rst1", F, S_NONE, 0);
        rst = 1'b0;

        // lw, memory ready on the first MEM cycle
        OP = 6'd35; mem_ready = 1'b1;
        cyc("lw.f", F, S_FETCH, 0);
        cyc("lw.d", D, S_DEC, 0);
        cyc("lw.e", E, S_LWSW_EX, 0);
        cyc("lw.m", M, S_LW_MEM, 0);
        cyc("lw.w", W, S_LW_WB, 0);

        // sw with three wait cycles
        OP = 6'd43; mem_ready = 1'b0;
        cyc("sw.f", F, S_FETCH, 0);
        cyc("sw.d", D, S_DEC, 0);
        cyc("sw.e", E, S_LWSW_EX, 0);
        for (int i = 0; i < 3; i++) cyc("sw.mwait", M, S_SW_MEM, 0);
        mem_ready = 1'b1;
        cyc("sw.mdone", M, S_SW_MEM, 0);

        // beq taken, then not taken
        OP = 6'd4; zero = 1'b1;
        cyc("beqt.f", F, S_FETCH, 0);
        cyc("beqt.d", D, S_DEC, 0);
        cyc("beqt.e", E, S_BEQ_T, 0);
        zero = 1'b0;
        cyc("beqn.f", F, S_FETCH, 0);
        cyc("beqn.d", D, S_DEC, 0);
        cyc("beqn.e", E, S_BEQ_N, 0);

        // R-type and
        OP = 6'd0; Funct = 6'd36;
        cyc("and.f", F, S_FETCH, 0);
        cyc("and.d", D, S_DEC, 0);
        cyc("and.e", E, S_AND_EX, 0);
        cyc("and.w", W, S_R_WB, 0);

        // jal
        OP = 6'd3;
        cyc("jal.f", F, S_FETCH, 0);
        cyc("jal.d", D, S_DEC, 0);
        cyc("jal.j", J, S_JAL, 0);

        // ori
        OP = 6'd13;
        cyc("ori.f", F, S_FETCH, 0);
        cyc("ori.d", D, S_DEC, 0);
        cyc("ori.e", E, S_ORI_EX, 0);
        cyc("ori.w", W, S_ORI_WB, 0);

        // lw: ready arrives on the 15th MEM cycle, no timeout
        OP = 6'd35; mem_ready = 1'b0;
        cyc("lwb.f", F, S_FETCH, 0);
        cyc("lwb.d", D, S_DEC, 0);
        cyc("lwb.e", E, S_LWSW_EX, 0);
        for (int i = 0; i < 14; i++) cyc("lwb.mwait", M, S_LW_MEM, 0);
        mem_ready = 1'b1;
        cyc("lwb.mlast", M, S_LW_MEM, 0);
        cyc("lwb.w", W, S_LW_WB, 0);

        // lw: ready never arrives, timeout after 15 MEM cycles
        mem_ready = 1'b0;
        cyc("lwt.f", F, S_FETCH, 0);
        cyc("lwt.d", D, S_DEC, 0);
        cyc("lwt.e", E, S_LWSW_EX, 0);
        for (int i = 0; i < 15; i++) cyc("lwt.mwait", M, S_LW_MEM, 0);
        cyc("lwt.f2", F, S_FETCH, 1);
        cyc("lwt.d2", D, S_DEC, 1);
        rst = 1'b1;
        cyc("lwt.rst", F, S_NONE, 0);
        rst = 1'b0;
        cyc("post.f", F, S_FETCH, 0);

        // unknown opcode 63
        OP = 6'd63;
        cyc("ill.d", D, S_DEC, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        cyc("ill.t0", T, S_NONE, 0);
        cyc("ill.t1", T, S_NONE, 0);
        rst = 1'b1;
        cyc("ill.rst", F, S_NONE, 0);
        rst = 1'b0;
        cyc("ill.f", F, S_FETCH, 0);
`else
        cyc("ill.f", F, S_FETCH, 0);
`endif

        // R-type with unsupported funct
        OP = 6'd0; Funct = 6'd42;
        cyc("rbad.d", D, S_DEC, 0);
        cyc("rbad.e", E, S_NONE, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        cyc("rbad.t", T, S_NONE, 0);
`else
        cyc("rbad.f", F, S_FETCH, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end by time limit expected completion");
        $fatal(1, "watchdog");
    end

endmodule
